bus_activity_monitor: RTL and testbench

- Upstream companion of the profiling custom instruction. It watches the shared-bus handshake and generates the registered `busIdle` qualifier that gates the bus-idle profile counter.
- It also gathers its own bus statistics: transactions, data beats, errors and worst-case grant latency.
- The CPU reads and clears these statistics through its own custom-instruction slot.

---
 rtl/bus_activity_monitor.sv | 168 ++++++++++++++++
 tb/tb_bus_activity_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_activity_monitor.sv
// Bus handshake monitor: registered busIdle qualifier plus saturating bus statistics read/cleared via a CI slot.
// Optional grant-latency tracking (statistic 3) is enabled by defining BUS_MON_LATENCY_EN.
module bus_activity_monitor #(
  parameter logic [7:0] customId    = 8'h01,
  parameter int         nrOfMasters = 4,
  parameter int         cntWidth    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [nrOfMasters-1:0] busRequests,
  input  logic [nrOfMasters-1:0] busGrants,
  input  logic                   beginTransaction,
  input  logic                   endTransaction,
  input  logic                   dataValid,
  input  logic                   busError,
  input  logic                   start,
  input  logic [7:0]             ciN,
  input  logic [31:0]            valueA,
  input  logic [31:0]            valueB,
  output logic                   busIdle,
  output logic                   done,
  output logic [31:0]            result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t state, state_next;

  logic ci_hit;
  logic clear;
  logic freeze_set;
  logic unfreeze_set;
  logic frozen;
  logic txn_inc;
  logic beat_inc;
  logic err_inc;

  logic [cntWidth-1:0] txn_cnt;
  logic [cntWidth-1:0] beat_cnt;
  logic [cntWidth-1:0] err_cnt;
  logic [cntWidth-1:0] lat_max;
  logic [cntWidth-1:0] stat_sel;

  logic unused_bits;
  assign unused_bits = ^{valueA[31:2], valueB[31:3]};

  function automatic logic [cntWidth-1:0] sat_inc(input logic [cntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busIdle <= 1'b1;
    end else begin
      state   <= state_next;
      busIdle <= (state_next == IDLE);
    end
  end

  // Begin+end in the same cycle outside XFER is a complete zero-length transaction.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (beginTransaction)
          state_next = endTransaction ? IDLE : XFER;
        else if (|busRequests)
          state_next = ARB;
      end
      ARB: begin
        if (beginTransaction)
          state_next = endTransaction ? IDLE : XFER;
        else if (!(|busRequests) && !(|busGrants))
          state_next = IDLE;
      end
      XFER: begin
        if (endTransaction || busError)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ci_hit       = start && (ciN == customId);
  assign clear        = ci_hit && valueB[0];
  assign freeze_set   = ci_hit && valueB[1];
  assign unfreeze_set = ci_hit && valueB[2];

  assign txn_inc  = beginTransaction && (state != XFER);
  assign beat_inc = dataValid && (state == XFER);
  assign err_inc  = busError;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      frozen <= 1'b0;
    else if (freeze_set)
      frozen <= 1'b1;
    else if (unfreeze_set)
      frozen <= 1'b0;
  end

  // Clear takes priority over both counting and freeze.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_cnt  <= '0;
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      txn_cnt  <= '0;
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else if (!frozen) begin
      if (txn_inc)
        txn_cnt <= sat_inc(txn_cnt);
      if (beat_inc)
        beat_cnt <= sat_inc(beat_cnt);
      if (err_inc)
        err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef BUS_MON_LATENCY_EN
  logic [cntWidth-1:0] wait_cnt;
  logic [cntWidth-1:0] wait_now;

  // wait_now counts the current ARB cycle too, so a request-to-begin gap of N cycles records N.
  assign wait_now = sat_inc(wait_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      lat_max  <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
      lat_max  <= '0;
    end else begin
      if (state == ARB)
        wait_cnt <= wait_now;
      else
        wait_cnt <= '0;
      if (!frozen && (state == ARB) && (state_next == XFER) && (wait_now > lat_max))
        lat_max <= wait_now;
    end
  end
`else
  assign lat_max = '0;
`endif

  always_comb begin
    stat_sel = '0;
    case (valueA[1:0])
      2'd0: stat_sel = txn_cnt;
      2'd1: stat_sel = beat_cnt;
      2'd2: stat_sel = err_cnt;
      2'd3: stat_sel = lat_max;
      default: stat_sel = '0;
    endcase
  end

  assign done   = ci_hit;
  assign result = ci_hit ? 32'(stat_sel) : 32'd0;

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Self-checking bench for bus_activity_monitor: vector table plus hand sequences, checked through a scoreboard queue.
module tb_bus_activity_monitor;

  localparam logic [7:0] CID = 8'h01;
`ifdef BUS_MON_LATENCY_EN
  localparam logic [31:0] LAT_EXP = 32'd3;
`else
  localparam logic [31:0] LAT_EXP = 32'd0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  busRequests, busGrants;
  logic        beginTransaction, endTransaction, dataValid, busError, start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        busIdle, done;
  logic [31:0] result;
  logic        busIdle_s, done_s;
  logic [31:0] result_s;

  int tests = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bus_activity_monitor #(.customId(CID), .nrOfMasters(4), .cntWidth(32)) dut (
    .clock(clock), .reset(reset), .busRequests(busRequests), .busGrants(busGrants),
    .beginTransaction(beginTransaction), .endTransaction(endTransaction),
    .dataValid(dataValid), .busError(busError), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .busIdle(busIdle), .done(done), .result(result)
  );

  bus_activity_monitor #(.customId(CID), .nrOfMasters(4), .cntWidth(4)) dut_small (
    .clock(clock), .reset(reset), .busRequests(busRequests), .busGrants(busGrants),
    .beginTransaction(beginTransaction), .endTransaction(endTransaction),
    .dataValid(dataValid), .busError(busError), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .busIdle(busIdle_s), .done(done_s), .result(result_s)
  );

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        bt, et, dv, err, st;
    logic [7:0]  ci;
    logic [31:0] va, vb;
    logic        exp_idle;
    logic        exp_done;
    logic [31:0] exp_res;
    logic        chk_small;
    logic [31:0] exp_small;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[19];

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t vbus(input string n, input logic [3:0] req, input logic [3:0] gnt,
                                input logic bt, input logic et, input logic dv, input logic err,
                                input logic ei);
    vec_t v;
    v.name = n; v.req = req; v.gnt = gnt;
    v.bt = bt; v.et = et; v.dv = dv; v.err = err; v.st = 1'b0;
    v.ci = 8'h00; v.va = 32'd0; v.vb = 32'd0;
    v.exp_idle = ei; v.exp_done = 1'b0; v.exp_res = 32'd0;
    v.chk_small = 1'b0; v.exp_small = 32'd0;
    return v;
  endfunction

  function automatic vec_t vread(input string n, input logic [1:0] sel, input logic [31:0] vb,
                                 input logic [31:0] exp, input logic ei);
    vec_t v;
    v = vbus(n, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ei);
    v.st = 1'b1; v.ci = CID; v.va = {30'd0, sel}; v.vb = vb;
    v.exp_done = 1'b1; v.exp_res = exp;
    return v;
  endfunction

  task automatic drive_idle();
    busRequests = 4'd0; busGrants = 4'd0;
    beginTransaction = 1'b0; endTransaction = 1'b0; dataValid = 1'b0; busError = 1'b0;
    start = 1'b0; ciN = 8'h00; valueA = 32'd0; valueB = 32'd0;
  endtask

  task automatic cyc(input vec_t v);
    @(posedge clock);
    #1;
    busRequests = v.req; busGrants = v.gnt;
    beginTransaction = v.bt; endTransaction = v.et; dataValid = v.dv; busError = v.err;
    start = v.st; ciN = v.ci; valueA = v.va; valueB = v.vb;
    sb.push_back(v);
  endtask

  always @(negedge clock) begin : monitor
    vec_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".idle"}, 32'(busIdle), 32'(e.exp_idle));
      check({e.name, ".done"}, 32'(done), 32'(e.exp_done));
      check({e.name, ".result"}, result, e.exp_res);
      if (e.chk_small)
        check({e.name, ".small"}, result_s, e.exp_small);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t v;

    // Vector table: request-to-grant transaction, statistic reads, CI decode, out-of-state events.
    tbl[0]  = vbus("t0_req",   4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[1]  = vbus("t1_arb",   4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = vbus("t2_arb",   4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = vbus("t3_begin", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = vbus("t4_beat",  4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = vbus("t5_beat",  4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = vbus("t6_beat",  4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = vbus("t7_beat",  4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = vbus("t8_end",   4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = vread("t9_rd_txn",  2'd0, 32'd0, 32'd1, 1'b1);
    tbl[10] = vread("rd_beats",   2'd1, 32'd0, 32'd4, 1'b1);
    tbl[11] = vread("rd_errs",    2'd2, 32'd0, 32'd0, 1'b1);
    tbl[12] = vread("rd_lat",     2'd3, 32'd0, LAT_EXP, 1'b1);
    v = vread("ci_other", 2'd1, 32'd1, 32'd0, 1'b1);
    v.ci = 8'h02; v.exp_done = 1'b0; v.exp_res = 32'd0;
    tbl[13] = v;
    tbl[14] = vread("rd_beats_kept", 2'd1, 32'd0, 32'd4, 1'b1);
    tbl[15] = vbus("dv_in_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[16] = vread("rd_beats_idle", 2'd1, 32'd0, 32'd4, 1'b1);
    tbl[17] = vbus("err_in_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[18] = vread("rd_errs_idle", 2'd2, 32'd0, 32'd1, 1'b1);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Asynchronous reset in the middle of a transfer.
    cyc(vbus("rst_begin", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(vbus("rst_beat",  4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(posedge clock);
    #1;
    drive_idle();
    start = 1'b1; ciN = CID; valueA = 32'd0;
    #1;
    check("rst_pre_idle", 32'(busIdle), 32'd0);
    check("rst_pre_txn", result, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_idle", 32'(busIdle), 32'd1);
    for (int s = 0; s < 4; s++) begin
      valueA = s;
      #1;
      check($sformatf("rst_stat%0d", s), result, 32'd0);
    end
    @(posedge clock);
    #2;
    drive_idle();
    reset = 1'b0;
    cyc(vbus("rst_spur_end", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(vread("rst_rd_txn", 2'd0, 32'd0, 32'd0, 1'b1));

    for (int i = 0; i < 19; i++)
      cyc(tbl[i]);

    // Error abort followed by a spurious end.
    cyc(vread("ea_clear", 2'd1, 32'd1, 32'd4, 1'b1));
    cyc(vbus("ea_begin", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(vbus("ea_mid",   4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(vbus("ea_err",   4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(vbus("ea_spur",  4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(vread("ea_txn",   2'd0, 32'd0, 32'd1, 1'b1));
    cyc(vread("ea_errs",  2'd2, 32'd0, 32'd1, 1'b1));
    cyc(vread("ea_beats", 2'd1, 32'd0, 32'd0, 1'b1));

    // Freeze: counters hold while busIdle keeps following the FSM.
    cyc(vread("frz", 2'd0, 32'd2, 32'd1, 1'b1));
    for (int k = 0; k < 2; k++) begin
      cyc(vbus($sformatf("frz_begin%0d", k), 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      cyc(vbus($sformatf("frz_beat%0d", k),  4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      cyc(vbus($sformatf("frz_end%0d", k),   4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    cyc(vread("frz_txn",   2'd0, 32'd0, 32'd1, 1'b1));
    cyc(vread("frz_beats", 2'd1, 32'd0, 32'd0, 1'b1));
    cyc(vread("frz_both",  2'd0, 32'd6, 32'd1, 1'b1));
    cyc(vbus("frz_both_be", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(vread("frz_both_txn", 2'd0, 32'd0, 32'd1, 1'b1));
    cyc(vread("unfrz", 2'd0, 32'd4, 32'd1, 1'b1));
    cyc(vbus("unfrz_be", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(vread("unfrz_txn", 2'd0, 32'd0, 32'd2, 1'b1));
    cyc(vbus("cl_begin", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(vbus("cl_beat0", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc(vbus("cl_beat1", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc(vbus("cl_end",   4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc(vread("clr_rd",    2'd1, 32'd1, 32'd2, 1'b1));
    cyc(vread("clr_after", 2'd1, 32'd0, 32'd0, 1'b1));
    cyc(vread("clr_txn",   2'd0, 32'd0, 32'd0, 1'b1));

    // Clear in the same cycle as a counted begin: clear wins.
    v = vread("clr_evt", 2'd0, 32'd1, 32'd0, 1'b1);
    v.bt = 1'b1;
    cyc(v);
    cyc(vbus("clr_evt_end", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc(vread("clr_evt_txn", 2'd0, 32'd0, 32'd0, 1'b1));

    // Saturation: 20 beats on a 4-bit instance stops at 15.
    cyc(vbus("sat_begin", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int b = 0; b < 20; b++)
      cyc(vbus($sformatf("sat_beat%0d", b), 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc(vbus("sat_end", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v = vread("sat_rd", 2'd1, 32'd0, 32'd20, 1'b1);
    v.chk_small = 1'b1; v.exp_small = 32'd15;
    cyc(v);

    cyc(vbus("tail", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
